locked_adder_arbiter: RTL and testbench

- Controller that shares one combinational key-locked 16-bit adder (e.g. error_tolerant_type2_adder16_aor_enc32) between two requesters.
- Loads the 32-bit unlock key serially from the key-management port into a shadow register and commits it atomically to the adder's key input.
- Arbitrates operand requests round-robin, registers operands into the adder, captures the 17-bit result and returns it with a valid/ready handshake.
- Sits between the key-provisioning logic and the datapath clients.

---
 rtl/locked_adder_pkg.sv | 16 +
 rtl/key_shift_loader.sv | 53 +++++
 rtl/locked_adder_arbiter.sv | 134 +++++++++++++
 tb/tb_locked_adder_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/locked_adder_pkg.sv
// Shared types and default sizes for the key-locked adder arbiter.
package locked_adder_pkg;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned KEY_W     = 32;
    localparam int unsigned KEY_CNT_W = $clog2(KEY_W) + 1;

    typedef enum logic [2:0] {
        S_NOKEY,
        S_LOAD,
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

endpackage

// File: rtl/key_shift_loader.sv
// Serial LSB-first key shifter with bit counter; commits the full key atomically.
module key_shift_loader #(
    parameter int unsigned KEY_W = 32,
    parameter int unsigned CNT_W = $clog2(KEY_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             restart_i,
    input  logic             active_i,
    input  logic             key_valid_i,
    input  logic             key_bit_i,
    output logic             done_o,
    output logic [KEY_W-1:0] key_o
);

    localparam logic [CNT_W-1:0] KeyCnt = CNT_W'(KEY_W);

    logic [KEY_W-1:0] shift_q, shift_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        done_o  = active_i & ~restart_i & (cnt_q == KeyCnt);
        // A restart clears only the counter; stale shift bits get overwritten.
        if (restart_i) begin
            cnt_d = '0;
        end else if (active_i && key_valid_i && (cnt_q != KeyCnt)) begin
            shift_d = {key_bit_i, shift_q[KEY_W-1:1]};
            cnt_d   = cnt_q + 1'b1;
        end
        if (done_o) begin
            key_d = shift_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    assign key_o = key_q;

endmodule

// File: rtl/locked_adder_arbiter.sv
// Shares one key-locked adder between two requesters with round-robin grant
// and a serially provisioned unlock key.
module locked_adder_arbiter
    import locked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = locked_adder_pkg::WIDTH,
    parameter int unsigned KEY_W = locked_adder_pkg::KEY_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             key_load_i,
    input  logic             key_valid_i,
    input  logic             key_bit_i,
    output logic             key_ready_o,
    input  logic             req0_valid_i,
    input  logic             req1_valid_i,
    output logic             req0_ready_o,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             rsp0_valid_o,
    output logic             rsp1_valid_o,
    input  logic             rsp0_ready_i,
    input  logic             rsp1_ready_i,
    output logic [WIDTH:0]   rsp_sum_o,
    output logic [WIDTH-1:0] add1_o,
    output logic [WIDTH-1:0] add2_o,
    output logic [KEY_W-1:0] keyinput_o,
    input  logic [WIDTH:0]   result_i
);

    localparam int unsigned CntW = $clog2(KEY_W) + 1;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] add1_q, add1_d;
    logic [WIDTH-1:0] add2_q, add2_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             restart;
    logic             load_done;
    logic             pick1;

    key_shift_loader #(
        .KEY_W (KEY_W),
        .CNT_W (CntW)
    ) u_key_loader (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .restart_i   (restart),
        .active_i    (state_q == S_LOAD),
        .key_valid_i (key_valid_i),
        .key_bit_i   (key_bit_i),
        .done_o      (load_done),
        .key_o       (keyinput_o)
    );

    // grant_q holds the last winner; with both valid the other one wins.
    assign pick1 = req1_valid_i & (~req0_valid_i | ~grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        add1_d       = add1_q;
        add2_d       = add2_q;
        sum_d        = sum_q;
        restart      = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        case (state_q)
            S_NOKEY: begin
                if (key_load_i) begin
                    restart = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (key_load_i) begin
                    restart = 1'b1;
                end else if (load_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (key_load_i) begin
                    restart = 1'b1;
                    state_d = S_LOAD;
                end else if (req0_valid_i || req1_valid_i) begin
                    grant_d      = pick1;
                    req0_ready_o = ~pick1;
                    req1_ready_o = pick1;
                    add1_d       = pick1 ? req1_a_i : req0_a_i;
                    add2_d       = pick1 ? req1_b_i : req0_b_i;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                sum_d   = result_i;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (grant_q ? rsp1_ready_i : rsp0_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_NOKEY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_NOKEY;
            grant_q <= 1'b1;
            add1_q  <= '0;
            add2_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            add1_q  <= add1_d;
            add2_q  <= add2_d;
            sum_q   <= sum_d;
        end
    end

    assign key_ready_o  = (state_q == S_IDLE) | (state_q == S_EXEC) | (state_q == S_RESP);
    assign rsp0_valid_o = (state_q == S_RESP) & ~grant_q;
    assign rsp1_valid_o = (state_q == S_RESP) & grant_q;
    assign rsp_sum_o    = sum_q;
    assign add1_o       = add1_q;
    assign add2_o       = add2_q;

endmodule

// File: tb/tb_locked_adder_arbiter.sv
// Directed bench for locked_adder_arbiter with a behavioural key-locked adder.
module tb_locked_adder_arbiter;

    localparam logic [31:0] KEY_A = 32'h93B4C4CF;
    localparam logic [31:0] KEY_B = 32'h0F0FA5A5;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        key_load_i, key_valid_i, key_bit_i, key_ready_o;
    logic        req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    logic [15:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic        rsp0_valid_o, rsp1_valid_o, rsp0_ready_i, rsp1_ready_i;
    logic [16:0] rsp_sum_o;
    logic [15:0] add1_o, add2_o;
    logic [31:0] keyinput_o;
    logic [16:0] result_i;

    int checks = 0;
    int errors = 0;

    // Adder only produces the true sum under the correct key.
    assign result_i = (keyinput_o == KEY_A) ? ({1'b0, add1_o} + {1'b0, add2_o})
                                            : (({1'b0, add1_o} + {1'b0, add2_o}) ^ 17'h0A5A5);

    always #5 clk_i = ~clk_i;

    locked_adder_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_load_i   (key_load_i),
        .key_valid_i  (key_valid_i),
        .key_bit_i    (key_bit_i),
        .key_ready_o  (key_ready_o),
        .req0_valid_i (req0_valid_i),
        .req1_valid_i (req1_valid_i),
        .req0_ready_o (req0_ready_o),
        .req1_ready_o (req1_ready_o),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp0_ready_i (rsp0_ready_i),
        .rsp1_ready_i (rsp1_ready_i),
        .rsp_sum_o    (rsp_sum_o),
        .add1_o       (add1_o),
        .add2_o       (add2_o),
        .keyinput_o   (keyinput_o),
        .result_i     (result_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Feeds 32 bits LSB first after the load pulse; checks commit timing.
    task automatic feed_key(input logic [31:0] k, input logic [31:0] old_k, input bit gapped);
        for (int i = 0; i < 32; i++) begin
            key_valid_i = 1'b1;
            key_bit_i   = k[i];
            tick();
            if (gapped) begin
                key_valid_i = 1'b0;
                if (i != 31) tick();
            end
        end
        key_valid_i = 1'b0;
        chk("key_held_before_commit", keyinput_o, old_k);
        chk("key_ready_before_commit", key_ready_o, 1'b0);
        tick();
        chk("key_committed", keyinput_o, k);
        chk("key_ready_at_commit", key_ready_o, 1'b1);
    endtask

    initial begin
        rst_ni = 1'b0;
        key_load_i = 0; key_valid_i = 0; key_bit_i = 0;
        req0_valid_i = 0; req1_valid_i = 0; rsp0_ready_i = 0; rsp1_ready_i = 0;
        req0_a_i = 0; req0_b_i = 0; req1_a_i = 0; req1_b_i = 0;
        #2;
        chk("rst_keyinput", keyinput_o, 32'h0);
        chk("rst_outs", {key_ready_o, req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o}, 5'b0);
        chk("rst_datapath", {add1_o, add2_o, rsp_sum_o}, 49'h0);
        tick();
        rst_ni = 1'b1;

        // No key: request must never be readied.
        req0_valid_i = 1'b1; req0_a_i = 16'h0003; req0_b_i = 16'h0004;
        for (int i = 0; i < 20; i++) begin
            chk("nokey_req0_ready", req0_ready_o, 1'b0);
            chk("nokey_key_ready", key_ready_o, 1'b0);
            tick();
        end
        req0_valid_i = 1'b0;

        key_load_i = 1'b1;
        tick();
        key_load_i = 1'b0;
        feed_key(KEY_A, 32'h0, 1'b1);

        // Single req0 transaction with held response.
        req0_valid_i = 1'b1; req0_a_i = 16'h1234; req0_b_i = 16'h0FF0;
        #1;
        chk("req0_ready_same_cycle", {req0_ready_o, req1_ready_o}, 2'b10);
        tick();
        req0_valid_i = 1'b0;
        chk("exec_operands", {add1_o, add2_o}, {16'h1234, 16'h0FF0});
        chk("exec_no_rsp", rsp0_valid_o, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rsp0_valid_hold", {rsp0_valid_o, rsp1_valid_o}, 2'b10);
            chk("rsp0_sum_hold", rsp_sum_o, 17'h02224);
            tick();
        end
        rsp0_ready_i = 1'b1;
        tick();
        rsp0_ready_i = 1'b0;
        chk("rsp0_dropped", rsp0_valid_o, 1'b0);
        chk("idle_key_ready", key_ready_o, 1'b1);

        // Contention: last winner was req0, so grants run 1,0,1,0.
        req0_valid_i = 1'b1; req0_a_i = 16'hFFFF; req0_b_i = 16'h0001;
        req1_valid_i = 1'b1; req1_a_i = 16'h0100; req1_b_i = 16'h0200;
        rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = (k % 2 == 0);
            #1;
            chk("rr_ready", {req0_ready_o, req1_ready_o}, {~g, g});
            tick();
            chk("rr_exec_no_rsp", {rsp0_valid_o, rsp1_valid_o}, 2'b00);
            tick();
            chk("rr_rsp_channel", {rsp0_valid_o, rsp1_valid_o}, {~g, g});
            chk("rr_rsp_sum", rsp_sum_o, g ? 17'h00300 : 17'h10000);
            chk("rr_no_accept_in_resp", {req0_ready_o, req1_ready_o}, 2'b00);
            tick();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;

        // key_load during EXEC is ignored.
        req1_valid_i = 1'b1; req1_a_i = 16'h0005; req1_b_i = 16'h0006;
        #1;
        chk("req1_alone_ready", {req0_ready_o, req1_ready_o}, 2'b01);
        tick();
        req1_valid_i = 1'b0;
        key_load_i = 1'b1;
        tick();
        key_load_i = 1'b0;
        chk("exec_load_ignored_rsp", rsp1_valid_o, 1'b1);
        chk("exec_load_ignored_sum", rsp_sum_o, 17'h0000B);
        rsp1_ready_i = 1'b1;
        tick();
        rsp1_ready_i = 1'b0;
        chk("exec_load_ignored_idle", key_ready_o, 1'b1);

        // key_load in IDLE beats a simultaneous request.
        key_load_i = 1'b1; req1_valid_i = 1'b1;
        #1;
        chk("load_beats_req", {req0_ready_o, req1_ready_o}, 2'b00);
        tick();
        key_load_i = 1'b0;
        chk("loading_key_ready", key_ready_o, 1'b0);
        chk("loading_no_ready", req1_ready_o, 1'b0);
        chk("loading_old_key", keyinput_o, KEY_A);
        feed_key(KEY_B, KEY_A, 1'b0);
        chk("req1_after_reload", req1_ready_o, 1'b1);
        tick();
        req1_valid_i = 1'b0;
        tick();
        chk("in_resp_before_reset", rsp1_valid_o, 1'b1);

        // Asynchronous reset mid-RESP.
        rst_ni = 1'b0;
        #1;
        chk("rst_resp_outs", {key_ready_o, rsp0_valid_o, rsp1_valid_o}, 3'b0);
        chk("rst_resp_data", {keyinput_o, add1_o, add2_o, rsp_sum_o}, 81'h0);
        tick();
        rst_ni = 1'b1;
        req0_valid_i = 1'b1; req0_a_i = 16'hFFFF; req0_b_i = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_no_ready", req0_ready_o, 1'b0);
            tick();
        end

        // Asynchronous reset mid-LOAD, then full reload.
        key_load_i = 1'b1;
        tick();
        key_load_i = 1'b0;
        key_valid_i = 1'b1; key_bit_i = 1'b1;
        repeat (10) tick();
        key_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rst_load_outs", {key_ready_o, req0_ready_o, keyinput_o}, 34'h0);
        tick();
        rst_ni = 1'b1;
        chk("rst_load_no_ready", req0_ready_o, 1'b0);
        key_load_i = 1'b1;
        #1;
        chk("pulse_no_ready", req0_ready_o, 1'b0);
        tick();
        key_load_i = 1'b0;
        feed_key(KEY_A, 32'h0, 1'b0);
        chk("final_req0_ready", req0_ready_o, 1'b1);
        tick();
        req0_valid_i = 1'b0;
        tick();
        chk("final_carry_sum", {rsp0_valid_o, rsp_sum_o}, {1'b1, 17'h10000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
